// File: rtl/alu_operand_stage_if.sv
// Bundles the issue, writeback and ALU-facing handshake signals of the
// operand-fetch stage. The master side drives instructions and writebacks
// and consumes the operand bundle. The slave side is the stage itself.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  // Decoded-instruction issue side
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [2:0]      op_in;

  // Writeback of ALU results
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  // Registered operand bundle towards the ALU
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      ALU;
  logic [XLEN-1:0] Operand1;
  logic [XLEN-1:0] Operand2;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr, imm, use_imm, op_in,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid, ALU, Operand1, Operand2, out_rd
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr, imm, use_imm, op_in,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output out_valid, ALU, Operand1, Operand2, out_rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU. Holds the integer register file,
// resolves source operands with writeback forwarding, tracks in-flight
// destinations with a busy-bit scoreboard and hands a registered
// {op, Operand1, Operand2, rd} bundle to the ALU over valid/ready.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic                clock,
  input logic                reset,
  alu_operand_stage_if.slave bus
);

  localparam int AW = 5;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic            wb_write;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            rd_pending;
  logic            hazard;
  logic            accept;
  logic            ready;

  // x0 is never written, so a writeback aimed at it is simply dropped
  always_comb begin
    wb_write = bus.wb_en && (bus.wb_addr != '0);
  end

  // Source 1 read: x0 reads zero, a same-cycle writeback to the index wins over the stored value
  always_comb begin
    rs1_val = '0;
    if (bus.rs1_addr != '0) begin
      if (wb_write && (bus.wb_addr == bus.rs1_addr)) begin
        rs1_val = bus.wb_data;
      end else begin
        rs1_val = regs[bus.rs1_addr];
      end
    end
  end

  // Source 2 read: same resolution rules as source 1
  always_comb begin
    rs2_val = '0;
    if (bus.rs2_addr != '0) begin
      if (wb_write && (bus.wb_addr == bus.rs2_addr)) begin
        rs2_val = bus.wb_data;
      end else begin
        rs2_val = regs[bus.rs2_addr];
      end
    end
  end

  // A register stays pending only if its busy bit is set and no writeback releases it this cycle
  always_comb begin
    rs1_pending = busy[bus.rs1_addr] && !(bus.wb_en && (bus.wb_addr == bus.rs1_addr));
    rs2_pending = busy[bus.rs2_addr] && !(bus.wb_en && (bus.wb_addr == bus.rs2_addr));
    rd_pending  = busy[bus.rd_addr]  && !(bus.wb_en && (bus.wb_addr == bus.rd_addr));
    hazard      = rs1_pending || (rs2_pending && !bus.use_imm) || rd_pending;
  end

  // Ready depends only on hazards and on whether the output slot is free or draining, never on in_valid
  always_comb begin
    ready  = !hazard && (!bus.out_valid || bus.out_ready);
    accept = bus.in_valid && ready;
  end

  assign bus.in_ready = ready;

  // Next scoreboard: apply the writeback clear first so a same-index accept re-sets the bit
  always_comb begin
    busy_next = busy;
    if (bus.wb_en) begin
      busy_next[bus.wb_addr] = 1'b0;
    end
    if (accept && (bus.rd_addr != '0)) begin
      busy_next[bus.rd_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; reset forgets every in-flight destination
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Register file; writebacks arriving during reset are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output bundle: load on accept, drop valid once the ALU takes it, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.ALU       <= '0;
      bus.Operand1  <= '0;
      bus.Operand2  <= '0;
      bus.out_rd    <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.ALU       <= bus.op_in;
      bus.Operand1  <= rs1_val;
      bus.Operand2  <= bus.use_imm ? bus.imm : rs2_val;
      bus.out_rd    <= bus.rd_addr;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
